ram_cmd_master: RTL and testbench

- Command initiator for the single-port RAM slave's 10-bit command interface.
- Converts host read/write requests into the RAM's two-bit-opcode word sequence:
  - 00 = write-address
  - 01 = write-data
  - 10 = read-address
  - 11 = read-command
- Collects the read data returned with tx_valid and returns it to the host.
- Sits between the host/test sequencer and the RAM, driving its din/rx_valid and consuming its dout/tx_valid.

---
 rtl/ram_cmd_master.sv | 211 +++++++++++++++++++++
 tb/tb_ram_cmd_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_master.sv
// rtl/ram_cmd_master.sv - command initiator for the single-port RAM 10-bit command interface
module ram_cmd_master #(
  parameter int ADDR_CACHE = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       wr_done
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_CMD,
    RD_WAIT
  } state_t;

  // RAM opcodes carried in ram_din[9:8]
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_CMD  = 2'b11;

  localparam logic       CACHE_EN = (ADDR_CACHE != 0);
  // Last wait-count value; the timeout fires on the TIMEOUT-th RD_WAIT edge without data
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;

  // Request fields captured on the accept edge, used by the later words
  logic [7:0] cap_addr;
  logic [7:0] cap_wdata;

  // Per-direction address caches mirroring the RAM's own address registers
  logic [7:0] wr_cache;
  logic       wr_cache_vld;
  logic [7:0] rd_cache;
  logic       rd_cache_vld;
  logic [7:0] wr_cache_nx;
  logic       wr_cache_vld_nx;
  logic [7:0] rd_cache_nx;
  logic       rd_cache_vld_nx;

  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nx;

  // Next values of the registered outputs
  logic [9:0] din_nx;
  logic       rx_valid_nx;
  logic       rsp_valid_nx;
  logic [7:0] rsp_rdata_nx;
  logic       rsp_err_nx;
  logic       wr_done_nx;

  logic       accept;
  logic       wr_hit;
  logic       rd_hit;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);
  assign wr_hit    = CACHE_EN && wr_cache_vld && (req_addr == wr_cache);
  assign rd_hit    = CACHE_EN && rd_cache_vld && (req_addr == rd_cache);

  // State register plus all registered outputs, caches and the wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_cache     <= 8'd0;
      wr_cache_vld <= 1'b0;
      rd_cache     <= 8'd0;
      rd_cache_vld <= 1'b0;
      wait_cnt     <= 8'd0;
      ram_din      <= 10'd0;
      ram_rx_valid <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'd0;
      rsp_err      <= 1'b0;
      wr_done      <= 1'b0;
    end else begin
      state        <= state_nx;
      wr_cache     <= wr_cache_nx;
      wr_cache_vld <= wr_cache_vld_nx;
      rd_cache     <= rd_cache_nx;
      rd_cache_vld <= rd_cache_vld_nx;
      wait_cnt     <= wait_cnt_nx;
      ram_din      <= din_nx;
      ram_rx_valid <= rx_valid_nx;
      rsp_valid    <= rsp_valid_nx;
      rsp_rdata    <= rsp_rdata_nx;
      rsp_err      <= rsp_err_nx;
      wr_done      <= wr_done_nx;
    end
  end

  // Capture the request payload on the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr  <= 8'd0;
      cap_wdata <= 8'd0;
    end else if (accept) begin
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  // Next-state and next-output decode; the word for a state is prepared on
  // the edge entering it so that ram_din/ram_rx_valid come straight from flops
  always_comb begin
    state_nx        = state;
    wr_cache_nx     = wr_cache;
    wr_cache_vld_nx = wr_cache_vld;
    rd_cache_nx     = rd_cache;
    rd_cache_vld_nx = rd_cache_vld;
    wait_cnt_nx     = wait_cnt;
    din_nx          = 10'd0;
    rx_valid_nx     = 1'b0;
    rsp_valid_nx    = 1'b0;
    rsp_rdata_nx    = rsp_rdata;
    rsp_err_nx      = rsp_err;
    wr_done_nx      = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          rx_valid_nx = 1'b1;
          if (req_wr) begin
            if (wr_hit) begin
              state_nx = WR_DATA;
              din_nx   = {OP_WR_DATA, req_wdata};
            end else begin
              state_nx = WR_ADDR;
              din_nx   = {OP_WR_ADDR, req_addr};
            end
          end else begin
            if (rd_hit) begin
              state_nx = RD_CMD;
              din_nx   = {OP_RD_CMD, 8'd0};
            end else begin
              state_nx = RD_ADDR;
              din_nx   = {OP_RD_ADDR, req_addr};
            end
          end
        end
      end

      WR_ADDR: begin
        state_nx        = WR_DATA;
        din_nx          = {OP_WR_DATA, cap_wdata};
        rx_valid_nx     = 1'b1;
        wr_cache_nx     = cap_addr;
        wr_cache_vld_nx = 1'b1;
      end

      WR_DATA: begin
        state_nx   = IDLE;
        wr_done_nx = 1'b1;
      end

      RD_ADDR: begin
        state_nx        = RD_CMD;
        din_nx          = {OP_RD_CMD, 8'd0};
        rx_valid_nx     = 1'b1;
        rd_cache_nx     = cap_addr;
        rd_cache_vld_nx = 1'b1;
      end

      RD_CMD: begin
        state_nx    = RD_WAIT;
        wait_cnt_nx = 8'd0;
      end

      RD_WAIT: begin
        if (ram_tx_valid) begin
          state_nx     = IDLE;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = ram_dout;
          rsp_err_nx   = 1'b0;
        end else if (wait_cnt == TO_LAST) begin
          // RAM state is unknown after a lost read, so force an address resend
          state_nx        = IDLE;
          rsp_valid_nx    = 1'b1;
          rsp_rdata_nx    = 8'd0;
          rsp_err_nx      = 1'b1;
          rd_cache_vld_nx = 1'b0;
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_cmd_master.sv
// tb/tb_ram_cmd_master.sv - scoreboard bench for ram_cmd_master with a behavioural RAM
module tb_ram_cmd_master;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [7:0] req_addr = 8'd0;
  logic [7:0] req_wdata = 8'd0;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout = 8'd0;
  logic       ram_tx_valid = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       wr_done;

  logic       nc_req_valid = 1'b0;
  logic       nc_req_ready;
  logic       nc_req_wr = 1'b0;
  logic [7:0] nc_req_addr = 8'd0;
  logic [7:0] nc_req_wdata = 8'd0;
  logic [9:0] nc_din;
  logic       nc_rx_valid;
  logic [7:0] nc_dout = 8'd0;
  logic       nc_tx_valid = 1'b0;
  logic       nc_rsp_valid;
  logic [7:0] nc_rsp_rdata;
  logic       nc_rsp_err;
  logic       nc_wr_done;

  always #5 clk = ~clk;

  ram_cmd_master #(.ADDR_CACHE(1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wr_done(wr_done)
  );

  ram_cmd_master #(.ADDR_CACHE(0), .TIMEOUT(TO)) dut_nc (
    .clk(clk), .rst(rst),
    .req_valid(nc_req_valid), .req_ready(nc_req_ready), .req_wr(nc_req_wr),
    .req_addr(nc_req_addr), .req_wdata(nc_req_wdata),
    .ram_din(nc_din), .ram_rx_valid(nc_rx_valid),
    .ram_dout(nc_dout), .ram_tx_valid(nc_tx_valid),
    .rsp_valid(nc_rsp_valid), .rsp_rdata(nc_rsp_rdata), .rsp_err(nc_rsp_err),
    .wr_done(nc_wr_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         due;
    logic [7:0] d;
    logic       e;
  } rsp_t;

  logic [9:0] wq[$];
  rsp_t       rq[$];
  int         dq[$];
  logic [9:0] nc_obs[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM slave
  logic [7:0] mem[256];
  logic [7:0] exp_mem[256];
  logic [7:0] ram_wa = 8'd0;
  logic [7:0] ram_ra = 8'd0;
  logic       ram_mute = 1'b0;
  logic       stray = 1'b0;

  always @(posedge clk) begin
    ram_tx_valid <= stray;
    if (stray) ram_dout <= 8'hEE;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: ram_wa <= ram_din[7:0];
        2'b01: mem[ram_wa] <= ram_din[7:0];
        2'b10: ram_ra <= ram_din[7:0];
        default: begin
          if (!ram_mute) begin
            ram_tx_valid <= 1'b1;
            ram_dout     <= mem[ram_ra];
          end
        end
      endcase
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT produces something
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_rx_valid) begin
        if (wq.size() == 0) expect_eq("word_unexpected", ram_rx_valid, 0);
        else expect_eq("word", ram_din, wq.pop_front());
      end else begin
        expect_eq("din_idle", ram_din, 0);
      end
      if (rsp_valid) begin
        if (rq.size() == 0) expect_eq("rsp_unexpected", rsp_valid, 0);
        else begin
          rsp_t r;
          r = rq.pop_front();
          expect_eq("rsp_rdata", rsp_rdata, r.d);
          expect_eq("rsp_err", rsp_err, r.e);
          expect_eq("rsp_lat", cyc, r.due);
        end
      end
      if (wr_done) begin
        if (dq.size() == 0) expect_eq("wr_done_unexpected", wr_done, 0);
        else expect_eq("wr_done_lat", cyc, dq.pop_front());
      end
      if (nc_rx_valid) nc_obs.push_back(nc_din);
    end
  end

  // Bench-side cache prediction
  logic       wr_cv = 1'b0;
  logic [7:0] wr_ca = 8'd0;
  logic       rd_cv = 1'b0;
  logic [7:0] rd_ca = 8'd0;

  task automatic do_req(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input logic mute, input logic keep, input logic want_rsp);
    logic hit;
    int   lat;
    int   n;
    int   acc;
    rsp_t r;
    @(negedge clk);
    if (wr) begin
      hit = wr_cv && (a == wr_ca);
      if (!hit) wq.push_back({2'b00, a});
      wq.push_back({2'b01, d});
      wr_cv = 1'b1;
      wr_ca = a;
      exp_mem[a] = d;
      lat = hit ? 1 : 2;
    end else begin
      hit = rd_cv && (a == rd_ca);
      if (!hit) wq.push_back({2'b10, a});
      wq.push_back(10'h300);
      rd_cv = 1'b1;
      rd_ca = a;
      lat = hit ? 2 : 3;
      if (mute) begin
        lat = lat + TO - 1;
        rd_cv = 1'b0;
      end
    end
    ram_mute  = mute;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) expect_eq("accept_timeout", req_ready, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep) req_valid = 1'b0;
    if (wr) dq.push_back(acc + lat);
    else if (want_rsp) begin
      r.due = acc + lat;
      r.d   = mute ? 8'h00 : exp_mem[a];
      r.e   = mute;
      rq.push_back(r);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 100 && !(req_ready && wq.size() == 0 && rq.size() == 0 && dq.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    expect_eq("drain", wq.size() + rq.size() + dq.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    // Requests during reset must be ignored
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 8'h77;
    req_wdata = 8'h99;
    repeat (3) @(negedge clk);
    expect_eq("reset_outs", {ram_din, ram_rx_valid, rsp_valid, rsp_rdata, rsp_err, wr_done}, 0);
    expect_eq("reset_ready", req_ready, 1);
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write miss: two words, ready low for two cycles
    do_req(1'b1, 8'h12, 8'h3C, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_eq("wmiss_ready0", req_ready, 0);
    @(negedge clk);
    expect_eq("wmiss_ready1", req_ready, 0);
    @(negedge clk);
    expect_eq("wmiss_ready2", req_ready, 1);
    drain();

    // Write hit: data word only
    do_req(1'b1, 8'h12, 8'h55, 1'b0, 1'b0, 1'b0);
    drain();

    // Same two writes on the uncached instance: both words each time
    nc_req_wr = 1'b1; nc_req_addr = 8'h12; nc_req_wdata = 8'h3C; nc_req_valid = 1'b1;
    @(posedge clk); #1; nc_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    nc_req_wdata = 8'h55; nc_req_valid = 1'b1;
    @(posedge clk); #1; nc_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    expect_eq("nc_words", nc_obs.size(), 4);
    if (nc_obs.size() == 4) begin
      expect_eq("nc_w0", nc_obs[0], {2'b00, 8'h12});
      expect_eq("nc_w1", nc_obs[1], {2'b01, 8'h3C});
      expect_eq("nc_w2", nc_obs[2], {2'b00, 8'h12});
      expect_eq("nc_w3", nc_obs[3], {2'b01, 8'h55});
    end

    // Read miss then read hit
    do_req(1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();
    do_req(1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();

    // Stray ram_tx_valid while idle is ignored
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);

    // Timeout, then the same address resends its address word
    do_req(1'b1, 8'h34, 8'hA5, 1'b0, 1'b0, 1'b0);
    drain();
    do_req(1'b0, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1);
    drain();
    do_req(1'b0, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset during RD_WAIT abandons the read and clears the caches
    do_req(1'b0, 8'h12, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_eq("midrst_outs", {ram_din, ram_rx_valid, rsp_valid, rsp_rdata, rsp_err, wr_done}, 0);
    expect_eq("midrst_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    wr_cv = 1'b0;
    rd_cv = 1'b0;
    ram_mute = 1'b0;
    repeat (TO + 3) @(negedge clk);
    do_req(1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();

    // Continuous req_valid with alternating write/read
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      do_req(1'b1, 8'h80 + 8'(i), d, 1'b0, 1'b1, 1'b0);
      do_req(1'b0, 8'h80 + 8'(i), 8'h00, 1'b0, (i != 5), 1'b1);
    end
    drain();

    repeat (5) @(negedge clk);
    expect_eq("final_empty", wq.size() + rq.size() + dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
